// File: rtl/rom_loader.sv
// rom_loader: buffers HPS download bytes in a small FIFO, optionally strips a copier
// header, writes the payload to cartridge memory over req/ack and reports size/mask.
module rom_loader #(
   parameter int AW        = 22,
   parameter int FIFO_LOG2 = 2,
   parameter int INDEX     = 0,
   parameter int HDR_BYTES = 512
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          ioctl_download,
   input  logic [7:0]    ioctl_index,
   input  logic          ioctl_wr,
   input  logic [24:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   output logic          ioctl_wait,
   input  logic          hdr_skip,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_din,
   output logic          mem_req,
   input  logic          mem_ack,
   output logic [AW:0]   rom_size,
   output logic [AW-1:0] rom_mask,
   output logic          core_reset,
   output logic          load_done,
   output logic          overflow,
   output logic [1:0]    dbg_state
);

   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam int PW    = FIFO_LOG2 + 1;
   localparam logic [AW-1:0] MIN_MASK = AW'(14'h3FFF);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          skip_q, skip_d;
   logic [AW:0]   rom_size_q, rom_size_d;
   logic [AW-1:0] rom_mask_q, rom_mask_d;
   logic          overflow_q, overflow_d;
   logic          core_reset_q, core_reset_d;
   logic          load_done_q, load_done_d;
   logic          wait_q, wait_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic          req_q, req_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    din_q, din_d;
   logic [AW+7:0] fifo_q [DEPTH];

   logic [24:0]   off;
   logic [AW:0]   off_inc;
   logic [PW-1:0] occ;
   logic [AW+7:0] head;
   logic [AW-1:0] size_m1, smear;
   logic          fifo_empty, fifo_full, start, wr_ok, in_hdr, off_big, push, drop, pop;
   logic          unused_idx;

   assign unused_idx = ^ioctl_index[7:6];
   assign start      = (state_q == S_IDLE) && ioctl_download && (ioctl_index[5:0] == 6'(INDEX));
   assign off        = ioctl_addr - (skip_q ? 25'(HDR_BYTES) : 25'd0);
   assign off_inc    = {1'b0, off[AW-1:0]} + (AW+1)'(1);
   assign in_hdr     = skip_q && (ioctl_addr < 25'(HDR_BYTES));
   assign off_big    = |off[24:AW];
   // Extra pointer bit makes the difference range 0..DEPTH, so full and empty differ.
   assign occ        = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (occ == '0);
   assign fifo_full  = (occ == PW'(DEPTH));
   assign wr_ok      = (state_q == S_LOAD) && ioctl_wr;
   assign push       = wr_ok && !in_hdr && !off_big && !fifo_full;
   assign drop       = wr_ok && !in_hdr && (off_big || fifo_full);
   assign pop        = req_q && mem_ack;
   assign head       = fifo_q[rd_ptr_q[FIFO_LOG2-1:0]];

   // Mask is the size rounded up to a power of two, never below a 16 KiB bank.
   always_comb begin
      size_m1 = rom_size_q[AW-1:0] - AW'(1);
      smear   = size_m1;
      for (int i = AW - 2; i >= 0; i--) smear[i] = smear[i+1] | size_m1[i];
   end

   always_comb begin
      state_d      = state_q;
      skip_d       = skip_q;
      rom_size_d   = rom_size_q;
      rom_mask_d   = rom_mask_q;
      overflow_d   = overflow_q;
      core_reset_d = core_reset_q;
      load_done_d  = 1'b0;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      req_d        = req_q;
      addr_d       = addr_q;
      din_d        = din_q;
      wait_d       = (occ >= PW'(DEPTH - 2)) || (state_q == S_DRAIN) || (state_q == S_DONE);

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
         if (off_inc > rom_size_q) rom_size_d = off_inc;
      end
      if (drop) overflow_d = 1'b1;

      // The head stays in the FIFO until acked, so req drops for a cycle between words.
      if (pop) begin
         req_d    = 1'b0;
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else if (!req_q && !fifo_empty) begin
         req_d  = 1'b1;
         addr_d = head[AW+7:8];
         din_d  = head[7:0];
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_LOAD;
               skip_d       = hdr_skip;
               rom_size_d   = '0;
               overflow_d   = 1'b0;
               wr_ptr_d     = '0;
               rd_ptr_d     = '0;
               core_reset_d = 1'b1;
            end
         end
         S_LOAD: begin
            if (!ioctl_download) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (fifo_empty && !req_q) begin
               state_d      = S_DONE;
               load_done_d  = 1'b1;
               core_reset_d = 1'b0;
               rom_mask_d   = (rom_size_q == '0) ? MIN_MASK : (smear | MIN_MASK);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         skip_q       <= 1'b0;
         rom_size_q   <= '0;
         rom_mask_q   <= MIN_MASK;
         overflow_q   <= 1'b0;
         core_reset_q <= 1'b0;
         load_done_q  <= 1'b0;
         wait_q       <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         req_q        <= 1'b0;
         addr_q       <= '0;
         din_q        <= '0;
      end else begin
         state_q      <= state_d;
         skip_q       <= skip_d;
         rom_size_q   <= rom_size_d;
         rom_mask_q   <= rom_mask_d;
         overflow_q   <= overflow_d;
         core_reset_q <= core_reset_d;
         load_done_q  <= load_done_d;
         wait_q       <= wait_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         req_q        <= req_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push) fifo_q[wr_ptr_q[FIFO_LOG2-1:0]] <= {off[AW-1:0], ioctl_dout};
   end

   assign ioctl_wait = wait_q;
   assign mem_addr   = addr_q;
   assign mem_din    = din_q;
   assign mem_req    = req_q;
   assign rom_size   = rom_size_q;
   assign rom_mask   = rom_mask_q;
   assign core_reset = core_reset_q;
   assign load_done  = load_done_q;
   assign overflow   = overflow_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: a behavioural HPS driver, a memory responder with
// configurable ack delay, and an expected-write queue checked in order.
`timescale 1ns/1ps
module tb_rom_loader;

   localparam int AW = 22;

   logic          clk_sys = 1'b0;
   logic          reset = 1'b1;
   logic          ioctl_download = 1'b0;
   logic [7:0]    ioctl_index = 8'h00;
   logic          ioctl_wr = 1'b0;
   logic [24:0]   ioctl_addr = '0;
   logic [7:0]    ioctl_dout = '0;
   logic          ioctl_wait;
   logic          hdr_skip = 1'b0;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din;
   logic          mem_req;
   logic          mem_ack;
   logic [AW:0]   rom_size;
   logic [AW-1:0] rom_mask;
   logic          core_reset;
   logic          load_done;
   logic          overflow;
   logic [1:0]    dbg_state;

   logic [AW+7:0] exp_q[$];
   int            n_vec = 0;
   int            n_err = 0;
   int            ack_delay = 0;
   int            ld_cnt = 0;
   int            req_cnt = 0;
   int            cr_err = 0;
   bit            load_active = 1'b0;
   bit            skip_m = 1'b0;

   rom_loader #(.AW(AW), .FIFO_LOG2(2), .INDEX(0), .HDR_BYTES(512)) dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
      .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .hdr_skip(hdr_skip),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_req(mem_req), .mem_ack(mem_ack),
      .rom_size(rom_size), .rom_mask(rom_mask), .core_reset(core_reset),
      .load_done(load_done), .overflow(overflow), .dbg_state(dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk_sys = ~clk_sys;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pat(input logic [24:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   // ---------------- monitors ----------------
   logic req_prev = 1'b0;
   initial forever begin
      @(negedge clk_sys);
      if (load_done) ld_cnt++;
      if (mem_req && !req_prev) req_cnt++;
      req_prev = mem_req;
      if (load_active && !core_reset) cr_err++;
   end

   // Memory responder: acks ack_delay cycles after a request is first seen.
   initial begin
      bit            req_seen;
      int            wait_cnt;
      logic [AW+7:0] hold_w, e;
      req_seen = 1'b0;
      wait_cnt = 0;
      hold_w   = '0;
      mem_ack  = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (mem_ack) mem_ack = 1'b0;
         else if (!mem_req) req_seen = 1'b0;
         else begin
            if (!req_seen) begin
               req_seen = 1'b1;
               wait_cnt = 0;
               hold_w   = {mem_addr, mem_din};
            end
            check("req_hold", 32'({mem_addr, mem_din}), 32'(hold_w));
            if (wait_cnt >= ack_delay) begin
               mem_ack  = 1'b1;
               req_seen = 1'b0;
               if (exp_q.size() == 0) check("wr_extra", exp_q.size(), 1);
               else begin
                  e = exp_q.pop_front();
                  check("wr_data", 32'({mem_addr, mem_din}), 32'(e));
               end
            end else wait_cnt++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_byte(input logic [24:0] a, input bit honor, input bit dropped);
      int          guard;
      logic [24:0] off;
      guard = 0;
      if (honor) begin
         while (ioctl_wait && guard < 2000) begin
            @(negedge clk_sys);
            guard++;
         end
         if (guard >= 2000) check("wait_timeout", guard, 0);
      end
      off = a - (skip_m ? 25'd512 : 25'd0);
      if (!(skip_m && a < 25'd512) && off < 25'h400000 && !dropped)
         exp_q.push_back({off[AW-1:0], pat(a)});
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = pat(a);
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
   endtask

   task automatic start_load(input logic [7:0] idx, input bit skip);
      hdr_skip       = skip;
      skip_m         = skip;
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      hdr_skip = ~skip;
      check("core_rst_on", core_reset, 1);
      check("state_load", dbg_state, 1);
      check("ovf_clr", overflow, 0);
      check("size_clr", rom_size, 0);
      load_active = 1'b1;
   endtask

   task automatic end_load(input logic [AW:0] exp_size, input logic [AW-1:0] exp_mask);
      int guard;
      int l0;
      guard = 0;
      l0 = ld_cnt;
      load_active    = 1'b0;
      ioctl_download = 1'b0;
      while (!load_done && guard < 5000) begin
         @(negedge clk_sys);
         guard++;
      end
      check("done_seen", load_done, 1);
      check("core_rst_at_done", core_reset, 0);
      check("rom_size", rom_size, exp_size);
      check("rom_mask", rom_mask, exp_mask);
      check("exp_empty", exp_q.size(), 0);
      @(negedge clk_sys);
      check("done_pulse", load_done, 0);
      @(negedge clk_sys);
      check("done_count", ld_cnt - l0, 1);
      check("state_idle", dbg_state, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int r0, l0;
      repeat (2) @(negedge clk_sys);
      check("rst_req", mem_req, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_din", mem_din, 0);
      check("rst_wait", ioctl_wait, 0);
      check("rst_core", core_reset, 0);
      check("rst_done", load_done, 0);
      check("rst_ovf", overflow, 0);
      check("rst_size", rom_size, 0);
      check("rst_mask", rom_mask, 32'h3FFF);
      check("rst_state", dbg_state, 0);
      reset = 1'b0;
      @(negedge clk_sys);

      // 4 KiB sequential plus last byte of a 32 KiB image, zero-wait ack
      ack_delay = 0;
      start_load(8'h00, 1'b0);
      for (int i = 0; i < 4096; i++) load_byte(25'(i), 1'b1, 1'b0);
      load_byte(25'h7FFF, 1'b1, 1'b0);
      end_load(23'h8000, 22'h7FFF);

      // header strip; hdr_skip flips after start to prove it is latched
      start_load(8'h00, 1'b1);
      for (int i = 0; i < 512 + 4096; i++) load_byte(25'(i), 1'b1, 1'b0);
      end_load(23'h1000, 22'h3FFF);
      check("hdr_no_ovf", overflow, 0);

      // slow ack: wait threshold and in-order delivery
      ack_delay = 20;
      start_load(8'h00, 1'b0);
      load_byte(25'd0, 1'b0, 1'b0);
      load_byte(25'd1, 1'b0, 1'b0);
      check("wait_lag", ioctl_wait, 0);
      @(negedge clk_sys);
      check("wait_thr", ioctl_wait, 1);
      for (int i = 2; i < 16; i++) load_byte(25'(i), 1'b1, 1'b0);
      end_load(23'h10, 22'h3FFF);
      check("slow_no_ovf", overflow, 0);

      // push into a full FIFO: fifth byte is lost
      start_load(8'h00, 1'b0);
      for (int i = 0; i < 5; i++) load_byte(25'(i), 1'b0, i == 4);
      for (int i = 5; i < 8; i++) load_byte(25'(i), 1'b1, 1'b0);
      end_load(23'h8, 22'h3FFF);
      check("full_ovf", overflow, 1);
      repeat (3) @(negedge clk_sys);
      check("full_ovf_sticky", overflow, 1);

      // zero-length load (start also clears overflow)
      ack_delay = 0;
      start_load(8'h00, 1'b0);
      repeat (3) @(negedge clk_sys);
      end_load(23'h0, 22'h3FFF);

      // non-matching index is ignored
      r0 = req_cnt;
      l0 = ld_cnt;
      ioctl_index    = 8'h41;
      ioctl_download = 1'b1;
      repeat (3) @(negedge clk_sys);
      for (int i = 0; i < 4; i++) begin
         ioctl_wr   = 1'b1;
         ioctl_addr = 25'(i);
         @(negedge clk_sys);
         ioctl_wr = 1'b0;
      end
      check("nm_core", core_reset, 0);
      check("nm_state", dbg_state, 0);
      ioctl_download = 1'b0;
      repeat (5) @(negedge clk_sys);
      check("nm_req", req_cnt - r0, 0);
      check("nm_done", ld_cnt - l0, 0);

      // top of address space, then an out-of-range byte
      start_load(8'h00, 1'b0);
      load_byte(25'h3FFFFF, 1'b1, 1'b0);
      load_byte(25'h400000, 1'b1, 1'b0);
      end_load(23'h400000, 22'h3FFFFF);
      check("range_ovf", overflow, 1);

      // reset mid-load with a request outstanding
      ack_delay = 20;
      start_load(8'h00, 1'b0);
      for (int i = 0; i < 4; i++) load_byte(25'(i), 1'b0, 1'b0);
      check("mid_req", mem_req, 1);
      l0 = ld_cnt;
      reset          = 1'b1;
      ioctl_download = 1'b0;
      load_active    = 1'b0;
      #1;
      check("mr_req", mem_req, 0);
      check("mr_addr", mem_addr, 0);
      check("mr_din", mem_din, 0);
      check("mr_wait", ioctl_wait, 0);
      check("mr_core", core_reset, 0);
      check("mr_ovf", overflow, 0);
      check("mr_size", rom_size, 0);
      check("mr_mask", rom_mask, 32'h3FFF);
      check("mr_state", dbg_state, 0);
      exp_q.delete();
      repeat (2) @(negedge clk_sys);
      reset     = 1'b0;
      ack_delay = 0;
      @(negedge clk_sys);
      check("mr_no_done", ld_cnt - l0, 0);

      // subsequent load with upper index bits set still matches
      start_load(8'hC0, 1'b0);
      for (int i = 0; i < 4; i++) load_byte(25'(i), 1'b1, 1'b0);
      load_byte(25'h4000, 1'b1, 1'b0);
      end_load(23'h4001, 22'h7FFF);

      check("core_rst_hold", cr_err, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rom_loader.md
# rom_loader

Downstream consumer of the HPS file-download stream (`ioctl_*` outputs of the HPS I/O block). It buffers 8-bit download bytes in a small FIFO, optionally strips a 512-byte copier header, and writes the payload into cartridge memory through a req/ack handshake. It throttles the HPS with `ioctl_wait` and holds the console core in reset while loading. At the end of each load it reports ROM size and a power-of-two address mask to the mapper.

## Interface
Parameters:
- `AW`, 22: cartridge memory address width (bytes).
- `FIFO_LOG2`, 2: FIFO depth is 2^FIFO_LOG2 entries of {addr, data}.
- `INDEX`, 0: `ioctl_index[5:0]` value this loader accepts.
- `HDR_BYTES`, 512: header length discarded when `hdr_skip` is set.

Ports:
- `clk_sys`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ioctl_download`  in  1  download active level.
- `ioctl_index`  in  8  menu index of the current download.
- `ioctl_wr`  in  1  one-cycle byte strobe.
- `ioctl_addr`  in  25  file byte address.
- `ioctl_dout`  in  8  file byte.
- `ioctl_wait`  out  1  backpressure to the HPS.
- `hdr_skip`  in  1  strip header; sampled at load start.
- `mem_addr`  out  AW  write address.
- `mem_din`  out  8  write data.
- `mem_req`  out  1  write request (level).
- `mem_ack`  in  1  one-cycle completion pulse.
- `rom_size`  out  AW+1  payload bytes written by the last load.
- `rom_mask`  out  AW  mapper address mask.
- `core_reset`  out  1  hold core in reset.
- `load_done`  out  1  one-cycle pulse at end of load.
- `overflow`  out  1  sticky; a byte was dropped. Cleared at load start.

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE → LOAD when `ioctl_download`=1 and `ioctl_index[5:0]`=INDEX. On entry:
  - latch `hdr_skip`;
  - clear `rom_size`, `overflow`, FIFO pointers;
  - assert `core_reset`.
- Downloads with a non-matching index are ignored entirely; state stays IDLE.
- LOAD: on each `ioctl_wr`, compute `off = ioctl_addr - (skip ? HDR_BYTES : 0)`.
  - If skip is set and `ioctl_addr` < HDR_BYTES, discard the byte.
  - If `off` ≥ 2^AW, discard the byte and set `overflow`.
  - Otherwise push {off[AW-1:0], `ioctl_dout`}.
  - A push while the FIFO is full discards the byte and sets `overflow`.
- `rom_size` = max(`rom_size`, off+1) over accepted bytes, updated on push.
- LOAD → DRAIN when `ioctl_download` falls. Later `ioctl_wr` strobes are ignored.
- DRAIN → DONE when the FIFO is empty and no request is outstanding.
- DONE, one cycle:
  - `rom_mask` = bit-smear of (`rom_size`-1), then OR with 14'h3FFF; minimum bank is 16 KiB.
  - If `rom_size`=0, `rom_mask` = 14'h3FFF.
  - Pulse `load_done`, drop `core_reset`, go to IDLE.
- A still-high matching `ioctl_download` in IDLE starts a new load (level-triggered).
- Memory port: the FIFO head is presented on `mem_addr`/`mem_din` with `mem_req`=1.
  - These outputs hold stable until `mem_ack`.
  - Pop on `mem_ack`.
  - `mem_ack` while `mem_req`=0 is ignored.
- `ioctl_wait` = 1 when FIFO occupancy ≥ 2^FIFO_LOG2 − 2, or state is DRAIN or DONE.

## Timing
- Reset values:
  - `mem_req`=0, `mem_addr`=0, `mem_din`=0;
  - `ioctl_wait`=0, `core_reset`=0, `load_done`=0, `overflow`=0;
  - `rom_size`=0, `rom_mask`=14'h3FFF;
  - state IDLE, FIFO empty.
- Reset mid-load aborts immediately. FIFO contents are lost and `load_done` is not pulsed.
- Load start: `core_reset` rises the cycle after the IDLE→LOAD edge.
- Push latency: `ioctl_wr` at edge N sets `mem_req`=1 after edge N+1 (FIFO was empty, no req pending).
- Ack to next request: `mem_ack` at edge M pops; the next head appears with `mem_req`=1 after edge M+1. `mem_req` is low for at least one cycle between requests. Throughput is 1 byte per 2 cycles with zero-wait ack.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- `ioctl_wait` is registered and asserts the cycle after the threshold is crossed. The two-slot margin absorbs one in-flight strobe.
- Download fall to `load_done`: DRAIN time + 1 cycle (DONE). `core_reset` deasserts in the same cycle `load_done` is high.
- Pointers wrap modulo 2^FIFO_LOG2. Full and empty are distinguished by an extra pointer bit.

## Test plan
- 32 KiB download, INDEX match, `hdr_skip`=0, `mem_ack` one cycle after each req:
  - memory holds bytes 0..0x7FFF;
  - `rom_size`=0x8000, `rom_mask`=0x7FFF;
  - one `load_done` pulse; `core_reset` high throughout the load.
- 16 KiB+512 file with `hdr_skip`=1: file byte 0x200 lands at `mem_addr` 0; `rom_size`=0x4000; `rom_mask`=0x3FFF; no writes for addresses < 0x200.
- `mem_ack` delayed 20 cycles, back-to-back `ioctl_wr`: `ioctl_wait` rises once occupancy reaches 2; no `overflow`; all bytes are written in order.
- Force a push into a full FIFO (ignore `ioctl_wait`): that byte is absent from memory; `overflow`=1 until the next load start.
- Zero-length download, and separately a download with non-matching index:
  - zero-length: `rom_size`=0, `rom_mask`=0x3FFF, `load_done` pulses;
  - non-matching: no `mem_req`, no `load_done`, `core_reset` stays 0.
- `reset` asserted mid-load with a request outstanding: all outputs return to reset values the same cycle; a subsequent load completes normally.
